// File: rtl/divide.sv
// divide: iterative unsigned restoring divider, one quotient bit per clock.
// Latency: 2*WIDTH+1 cycles from acceptance to out_valid (1 cycle for a zero
//   divisor when DIV_ZERO_FAST_EN is defined); issue interval >= 2*WIDTH+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (dividend 2*WIDTH, divisor WIDTH)
//   out_valid/out_ready result handshake (quotient 2*WIDTH, remainder WIDTH,
//                      div_by_zero)
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor skips the iterations
//   and completes on the acceptance edge with the same result values.
module divide #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(2*WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] d_sr;     // dividend shifts out the top, quotient bits in the bottom
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   p;        // partial remainder; always < divisor after a step

  logic [WIDTH:0]     p_shift;
  logic               ge;
  logic [WIDTH-1:0]   p_sub;
  logic [WIDTH-1:0]   p_nxt;
  logic [2*WIDTH-1:0] d_nxt;

  // One restoring step. The compare is WIDTH+1 bits so a shifted remainder
  // above the divisor range (e.g. 0x1FFFE vs 0xFFFF) is never truncated.
  // The subtraction only needs WIDTH bits: whenever it is taken the true
  // difference is below the divisor, so the carry-out is always zero.
  always_comb begin
    p_shift = {p, d_sr[2*WIDTH-1]};
    ge      = (p_shift >= {1'b0, dvs});
    p_sub   = p_shift[WIDTH-1:0] - dvs;
    p_nxt   = ge ? p_sub : p_shift[WIDTH-1:0];
    d_nxt   = {d_sr[2*WIDTH-2:0], ge};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (divisor == '0) ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      d_sr        <= '0;
      dvs         <= '0;
      p           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_sr <= dividend;
            dvs  <= divisor;
            p    <= '0;
            cnt  <= CW'(2*WIDTH);
`ifdef DIV_ZERO_FAST_EN
            // Same values the full iteration would produce for divisor 0
            if (divisor == '0) begin
              cnt         <= '0;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          p    <= p_nxt;
          d_sr <= d_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient    <= d_nxt;
            remainder   <= p_nxt;
            div_by_zero <= (dvs == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
